// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants for the elastic pipeline-stage register.
package pipe_stage_elastic_pkg;

  // Skid-buffer mode selectors for the SKID parameter.
  localparam int unsigned PIPE_SKID_OFF  = 0;
  localparam int unsigned PIPE_SKID_ON   = 1;

  // Default width of each performance counter.
  localparam int unsigned PIPE_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned W = PIPE_CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold at all-ones, clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between two adjacent stages: valid/ready
// handshake, optional two-entry skid buffer, flush, control-bit NOP gating
// and saturating stall/transfer counters.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned SKID      = PIPE_SKID_ON,
  parameter int unsigned CTRL_GATE = 1,
  parameter int unsigned CNT_W     = PIPE_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic              m_valid;
  logic              s_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] s_data;
  logic              in_fire;
  logic              out_fire;
  logic              stall_inc;

  // With the skid buffer, ready depends only on registered state (plus
  // flush/reset); without it, a full main register is free when downstream
  // takes the entry this cycle.
  assign in_ready = (SKID != 0) ? (rst & ~flush & ~s_valid)
                                : (rst & ~flush & (~m_valid | out_ready));

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid & out_ready;
  assign stall_inc = m_valid & ~out_ready;

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = ((CTRL_GATE != 0) && !m_valid) ? '0 : m_ctrl;

  // Main/skid register update: reset, then flush, then handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_ctrl  <= '0;
      s_ctrl  <= '0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      // Squash: valids and control drop, data is left as-is.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_ctrl  <= '0;
      s_ctrl  <= '0;
    end else if (SKID != 0) begin
      if (out_fire || !m_valid) begin
        if (s_valid) begin
          m_ctrl  <= s_ctrl;
          m_data  <= s_data;
          s_valid <= 1'b0;
        end else if (in_fire) begin
          m_ctrl  <= in_ctrl;
          m_data  <= in_data;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end
      // Main is occupied and stalled: park the arriving entry in the skid.
      if (m_valid && !out_ready && in_fire) begin
        s_ctrl  <= in_ctrl;
        s_data  <= in_data;
        s_valid <= 1'b1;
      end
    end else begin
      if (in_fire) begin
        m_ctrl  <= in_ctrl;
        m_data  <= in_data;
        m_valid <= 1'b1;
      end else if (out_fire) begin
        m_valid <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_xfer_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (out_fire),
    .cnt (xfer_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: three configurations
// (skid+gate, no-skid+gate, skid+no-gate) driven by directed and random
// stimulus and checked against a queue-based occupancy model.
module tb_pipe_stage_elastic;

  localparam int unsigned CW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned NW  = 4;
  localparam int          SAT = (1 << NW) - 1;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int ui, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL u%0d %s got=%0h exp=%0h", ui, nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int unsigned SK = (g == 1) ? 0 : 1;
    localparam int unsigned CG = (g == 2) ? 0 : 1;

    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [NW-1:0] stall_cnt, xfer_cnt;

    pipe_stage_elastic #(
      .CTRL_W    (CW),
      .DATA_W    (DW),
      .SKID      (SK),
      .CTRL_GATE (CG),
      .CNT_W     (NW)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .cnt_clr   (cnt_clr),
      .stall_cnt (stall_cnt),
      .xfer_cnt  (xfer_cnt)
    );

    ent_t          mq[$];   // entries held in the stage, oldest first
    ent_t          sb[$];   // expected outputs not yet consumed
    int            m_stall, m_xfer;
    logic [CW-1:0] m_ctrl;  // control value last presented (0 after reset/flush)
    logic [DW-1:0] m_data;  // data value last presented (0 after reset)
    bit            started = 0;
    bit            last_fire = 0;
    bit            fin = 0;

    // Capacity: two entries with a skid buffer; one otherwise, freed by a
    // same-cycle downstream accept.
    function automatic bit exp_rdy();
      if (!rst || flush) return 1'b0;
      if (SK != 0) return mq.size() < 2;
      return (mq.size() == 0) || out_ready;
    endfunction

    // Reference model: advance occupancy queue and counters at each edge.
    always @(posedge clk) begin
      bit   fi, fo;
      ent_t e;
      fi = in_valid && exp_rdy();
      fo = (mq.size() > 0) && out_ready;
      last_fire = fi;
      if (!rst) begin
        mq.delete();
        sb.delete();
        m_stall = 0;
        m_xfer  = 0;
        m_ctrl  = '0;
        m_data  = '0;
      end else begin
        if (cnt_clr) begin
          m_stall = 0;
          m_xfer  = 0;
        end else begin
          if ((mq.size() > 0) && !out_ready && (m_stall < SAT)) m_stall++;
          if (fo && (m_xfer < SAT)) m_xfer++;
        end
        if (flush) begin
          mq.delete();
          sb.delete();
          m_ctrl = '0;
        end else begin
          if (fo) void'(mq.pop_front());
          if (fi) begin
            e.c = in_ctrl;
            e.d = in_data;
            mq.push_back(e);
            sb.push_back(e);
          end
          if (mq.size() > 0) begin
            m_ctrl = mq[0].c;
            m_data = mq[0].d;
          end
        end
      end
      started = 1;
    end

    // Monitor: compare outputs mid-cycle, consume scoreboard on transfers.
    always @(negedge clk) begin
      bit   ev;
      ent_t h;
      if (started) begin
        ev = mq.size() > 0;
        check("in_ready", g, in_ready, exp_rdy());
        check("out_valid", g, out_valid, ev);
        if (ev) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL u%0d sb_head got=empty exp=entry", g);
          end else begin
            check("out_data", g, out_data, sb[0].d);
            check("out_ctrl", g, out_ctrl, sb[0].c);
          end
        end else begin
          check("idle_data", g, out_data, m_data);
          check("idle_ctrl", g, out_ctrl, (CG == 0) ? m_ctrl : '0);
        end
        if (out_valid && out_ready && (sb.size() > 0)) begin
          h = sb.pop_front();
        end
        check("stall_cnt", g, stall_cnt, m_stall);
        check("xfer_cnt", g, xfer_cnt, m_xfer);
      end
    end

    task automatic cyc();
      @(posedge clk);
      #1;
    endtask

    // Offer one entry until the model accepts it or the budget runs out.
    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input int budget);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = d;
      for (int i = 0; i < budget; i++) begin
        cyc();
        if (last_fire) break;
      end
    endtask

    // Stimulus: reset, streaming, backpressure, flush, bubble, saturation, random.
    initial begin
      int k;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = '1;
      out_ready = 1'b0; cnt_clr = 1'b0;
      repeat (3) cyc();
      rst = 1'b1; in_valid = 1'b0;
      cyc();

      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) send(CW'(i), DW'(i), 4);
      in_valid = 1'b0;
      repeat (3) cyc();

      cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
      out_ready = 1'b0;
      send(8'h11, 32'd1, 4);
      send(8'h12, 32'd2, 4);
      send(8'h13, 32'd3, 4);
      repeat (2) cyc();
      out_ready = 1'b1;
      send(8'h13, 32'd3, 4);
      in_valid = 1'b0;
      repeat (3) cyc();

      out_ready = 1'b0;
      send(8'h05, 32'd5, 4);
      send(8'h06, 32'd6, 4);
      in_valid = 1'b1; in_ctrl = 8'h07; in_data = 32'd7;
      cyc();
      flush = 1'b1; cyc(); flush = 1'b0; in_valid = 1'b0;
      cyc();
      out_ready = 1'b1;
      repeat (2) cyc();

      send(8'hA5, 32'h100, 4);
      in_valid = 1'b0;
      cyc();
      send(8'h3C, 32'h101, 4);
      in_valid = 1'b0;
      repeat (2) cyc();

      cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
      out_ready = 1'b0;
      send(8'h42, 32'h55, 4);
      in_valid = 1'b0;
      repeat (20) cyc();
      cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
      repeat (2) cyc();
      out_ready = 1'b1;
      repeat (3) cyc();

      for (int i = 0; i < 400; i++) begin
        in_valid  = $urandom_range(0, 3) != 0;
        in_ctrl   = CW'($urandom);
        in_data   = DW'($urandom);
        out_ready = $urandom_range(0, 2) != 0;
        flush     = $urandom_range(0, 15) == 0;
        cnt_clr   = $urandom_range(0, 31) == 0;
        rst       = $urandom_range(0, 63) != 0;
        cyc();
      end

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
      k = 0;
      while ((sb.size() != 0) && (k < 10)) begin
        cyc();
        k++;
      end
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL u%0d drain left=%0d exp=0", g, sb.size());
      end
      fin = 1;
    end
  end

  // Wait for every configuration to finish, bounded, then summarise.
  initial begin
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      if (u[0].fin && u[1].fin && u[2].fin) break;
    end
    if (!(u[0].fin && u[1].fin && u[2].fin)) begin
      total++;
      bad++;
      $display("FAIL timeout got=unfinished exp=finished");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
